adc_receiver: RTL and testbench

- Front end of the SDR receiver. Drives the encode clock and static control pins of a 16-bit parallel ADC, and captures signed ADC samples.
- Decimates samples into fixed-size blocks, computing a block mean and a peak magnitude for each block.
- Streams each block result as a 4-byte UART frame on TX[1] and shows status on the LEDs.
- Single clock domain. CLKOUTA is treated as a sampled status input only, never as a clock.

---
 rtl/adc_receiver_pkg.sv | 28 ++
 rtl/adc_receiver_uart_tx_byte.sv | 99 +++++++++
 rtl/adc_receiver.sv | 157 +++++++++++++++
 tb/tb_adc_receiver.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_receiver_pkg.sv
// Shared constants, UART state encoding and frame byte selection for adc_receiver.
package adc_receiver_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int         FRAME_LEN = 4;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_t;

   // Byte idx of a frame: sync word, mean high, mean low, peak high.
   function automatic logic [7:0] frame_byte(input logic [1:0] idx,
                                             input logic [15:0] mean,
                                             input logic [15:0] peak);
      logic [7:0] b;
      case (idx)
         2'd0:    b = SYNC_BYTE;
         2'd1:    b = mean[15:8];
         2'd2:    b = mean[7:0];
         default: b = peak[15:8];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/adc_receiver_uart_tx_byte.sv
// 8N1 byte transmitter. A start pulse in IDLE, or in the last cycle of STOP,
// loads the next byte so consecutive bytes follow with no idle gap.
module uart_tx_byte
   import adc_receiver_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       busy,
   output logic       done,
   output logic       txd
);

   localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);

   uart_state_t   state_reg, state_next;
   logic [CW-1:0] tick_reg, tick_next;
   logic [2:0]    bit_reg, bit_next;
   logic [7:0]    shift_reg, shift_next;
   logic          txd_reg, txd_next;
   logic          bit_end;

   assign bit_end = (tick_reg == LAST_TICK);

   // State register; the serial line itself is a flop so it never glitches.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= UART_IDLE;
         tick_reg  <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
         txd_reg   <= 1'b1;
      end else begin
         state_reg <= state_next;
         tick_reg  <= tick_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
         txd_reg   <= txd_next;
      end
   end

   // Next-state logic: each bit lasts CLKS_PER_BIT ticks.
   always_comb begin
      state_next = state_reg;
      tick_next  = bit_end ? '0 : tick_reg + 1'b1;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      case (state_reg)
         UART_IDLE: begin
            tick_next = '0;
            if (start) begin
               state_next = UART_START;
               shift_next = data;
               bit_next   = '0;
            end
         end
         UART_START: begin
            if (bit_end) state_next = UART_DATA;
         end
         UART_DATA: begin
            if (bit_end) begin
               shift_next = {1'b0, shift_reg[7:1]};
               bit_next   = bit_reg + 1'b1;
               if (bit_reg == 3'd7) state_next = UART_STOP;
            end
         end
         UART_STOP: begin
            if (bit_end) begin
               if (start) begin
                  state_next = UART_START;
                  shift_next = data;
                  bit_next   = '0;
               end else begin
                  state_next = UART_IDLE;
               end
            end
         end
         default: state_next = UART_IDLE;
      endcase
   end

   // Output decode: line level follows the state being entered, LSB first.
   always_comb begin
      busy = (state_reg != UART_IDLE);
      done = (state_reg == UART_STOP) && bit_end;
      case (state_next)
         UART_START: txd_next = 1'b0;
         UART_DATA:  txd_next = shift_next[0];
         default:    txd_next = 1'b1;
      endcase
   end

   assign txd = txd_reg;

endmodule

// File: rtl/adc_receiver.sv
// ADC front end: encode clock, sample capture, block mean/peak, UART framing, LEDs.
module adc_receiver
   import adc_receiver_pkg::*;
#(
   parameter int DECIM_LOG2   = 13,
   parameter int CLKS_PER_BIT = 434,
   parameter bit PGA_EN       = 1'b0,
   parameter bit DITH_EN      = 1'b0,
   parameter bit RAND_EN      = 1'b0,
   parameter int ALIVE_LOG2   = 16
) (
   input  logic        CLOCK_50,
   input  logic        rst,
   input  logic        CLKOUTA,
   input  logic [15:0] DA,
   output logic        PGA,
   output logic        DITH,
   output logic        RAND,
   output logic        ENC,
   output logic [7:0]  LED,
   output logic [2:1]  TX
);

   localparam int         SUM_W     = 16 + DECIM_LOG2;
   localparam logic [1:0] LAST_BYTE = 2'(FRAME_LEN - 1);

   logic [1:0]            cnt_reg;
   logic [15:0]           sample_reg;
   logic                  sample_valid_reg;
   logic [SUM_W-1:0]      sum_reg, sum_next, mean_full;
   logic [15:0]           peak_reg, peak_next, sample_abs;
   logic [DECIM_LOG2-1:0] count_reg;
   logic [15:0]           result_mean_reg, result_peak_reg;
   logic                  result_valid_reg;
   logic [15:0]           mean_lat_reg, peak_lat_reg;
   logic [1:0]            byte_idx_reg;
   logic                  frame_busy_reg;
   logic [6:0]            led_peak_reg;
   logic [2:0]            clkouta_sync_reg;
   logic [ALIVE_LOG2-1:0] alive_cnt_reg;
   logic                  alive, accept, tx_start, tx_busy, tx_done, txd;
   logic [7:0]            tx_data;

   assign PGA  = PGA_EN;
   assign DITH = DITH_EN;
   assign RAND = RAND_EN;

   // Divide-by-4 encode clock straight from the counter flop.
   always_ff @(posedge CLOCK_50) begin
      if (rst) cnt_reg <= '0;
      else     cnt_reg <= cnt_reg + 2'd1;
   end
   assign ENC = cnt_reg[1];

   // Capture DA three cycles after the ENC rising edge, when data has settled.
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         sample_reg       <= '0;
         sample_valid_reg <= 1'b0;
      end else begin
         sample_valid_reg <= (cnt_reg == 2'd0);
         if (cnt_reg == 2'd0) sample_reg <= DA;
      end
   end

   // Running sum, magnitude peak and block mean including the current sample.
   always_comb begin
      sample_abs = sample_reg[15] ? (16'd0 - sample_reg) : sample_reg;
      sum_next   = sum_reg + {{DECIM_LOG2{sample_reg[15]}}, sample_reg};
      peak_next  = (sample_abs > peak_reg) ? sample_abs : peak_reg;
      mean_full  = SUM_W'($signed(sum_next) >>> DECIM_LOG2);
   end

   // Block accumulation; on the last sample publish mean/peak and restart.
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         sum_reg          <= '0;
         peak_reg         <= '0;
         count_reg        <= '0;
         result_mean_reg  <= '0;
         result_peak_reg  <= '0;
         result_valid_reg <= 1'b0;
      end else begin
         result_valid_reg <= 1'b0;
         if (sample_valid_reg) begin
            if (&count_reg) begin
               sum_reg          <= '0;
               peak_reg         <= '0;
               count_reg        <= '0;
               result_mean_reg  <= mean_full[15:0];
               result_peak_reg  <= peak_next;
               result_valid_reg <= 1'b1;
            end else begin
               sum_reg   <= sum_next;
               peak_reg  <= peak_next;
               count_reg <= count_reg + 1'b1;
            end
         end
      end
   end

   // A result arriving while a frame is in flight is simply dropped.
   assign accept   = result_valid_reg && !frame_busy_reg;
   assign tx_start = accept || (tx_done && frame_busy_reg && (byte_idx_reg != LAST_BYTE));
   assign tx_data  = accept ? SYNC_BYTE
                            : frame_byte(byte_idx_reg + 2'd1, mean_lat_reg, peak_lat_reg);

   // Frame sequencer: latch the result, then step through the frame bytes.
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         mean_lat_reg   <= '0;
         peak_lat_reg   <= '0;
         byte_idx_reg   <= '0;
         frame_busy_reg <= 1'b0;
         led_peak_reg   <= '0;
      end else if (accept) begin
         mean_lat_reg   <= result_mean_reg;
         peak_lat_reg   <= result_peak_reg;
         byte_idx_reg   <= '0;
         frame_busy_reg <= 1'b1;
         led_peak_reg   <= result_peak_reg[15:9];
      end else if (tx_done && frame_busy_reg) begin
         if (byte_idx_reg == LAST_BYTE) frame_busy_reg <= 1'b0;
         else                           byte_idx_reg   <= byte_idx_reg + 2'd1;
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart (
      .clk  (CLOCK_50),
      .rst  (rst),
      .start(tx_start),
      .data (tx_data),
      .busy (tx_busy),
      .done (tx_done),
      .txd  (txd)
   );

   // CLKOUTA activity watchdog: two-flop synchronizer, edge detect, reloading timeout.
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         clkouta_sync_reg <= '0;
         alive_cnt_reg    <= '0;
      end else begin
         clkouta_sync_reg <= {clkouta_sync_reg[1:0], CLKOUTA};
         if (clkouta_sync_reg[1] && !clkouta_sync_reg[2]) alive_cnt_reg <= '1;
         else if (alive_cnt_reg != '0)                    alive_cnt_reg <= alive_cnt_reg - 1'b1;
      end
   end
   assign alive = (alive_cnt_reg != '0);

   assign LED   = {alive, led_peak_reg};
   assign TX[1] = txd;
   assign TX[2] = frame_busy_reg;

endmodule

// File: tb/tb_adc_receiver.sv
// Randomized scoreboard bench for adc_receiver with short blocks and fast UART.
module tb_adc_receiver;

   localparam int DL        = 4;
   localparam int CPB       = 8;
   localparam int AL        = 4;
   localparam int NS        = 1 << DL;
   localparam int BLK_CYC   = NS * 4;
   localparam int FRAME_CYC = 40 * CPB;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clk_sel = 1'b0;
   logic [15:0] da = 16'd0;
   logic        clkouta, pga, dith, rand_o, enc;
   logic [7:0]  led;
   logic [2:1]  tx;

   assign clkouta = clk_sel & enc;

   adc_receiver #(
      .DECIM_LOG2(DL), .CLKS_PER_BIT(CPB), .PGA_EN(1'b1), .DITH_EN(1'b0),
      .RAND_EN(1'b1), .ALIVE_LOG2(AL)
   ) dut (
      .CLOCK_50(clk), .rst(rst), .CLKOUTA(clkouta), .DA(da),
      .PGA(pga), .DITH(dith), .RAND(rand_o), .ENC(enc), .LED(led), .TX(tx)
   );

   always #10 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_q[$];
   int          samples[$];
   logic [6:0]  exp_led = '0;
   bit          mon_en = 1'b0;
   bit          mon_busy = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end else begin
         $display("ok   %s value=%0h", name, act);
      end
   endtask

   // Reference: blocks of NS samples; a result is sent only if the UART has
   // finished the previous 40-bit frame strictly before that block's handoff.
   task automatic model_frames();
      int last_start, sum, pk, a, mean;
      logic [15:0] m16, p16;
      last_start = -(FRAME_CYC + 1);
      for (int b = 0; b < samples.size() / NS; b++) begin
         if (b * BLK_CYC > last_start + FRAME_CYC) begin
            sum = 0;
            pk  = 0;
            for (int i = 0; i < NS; i++) begin
               a = samples[b * NS + i];
               sum += a;
               if (a < 0) a = -a;
               if (a > pk) pk = a;
            end
            mean = sum >>> DL;
            m16  = 16'(mean);
            p16  = 16'(pk);
            exp_q.push_back({8'hA5, m16, p16[15:8]});
            exp_led    = p16[15:9];
            last_start = b * BLK_CYC;
         end
      end
   endtask

   // Reset, then present one sample per encode period, changing DA two cycles after ENC rises.
   task automatic run_samples();
      int guard;
      mon_en = 1'b1;
      da  = 16'(samples[0]);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 1; i < samples.size(); i++) begin
         repeat (4) @(posedge clk);
         #1 da = 16'(samples[i]);
      end
      guard = 0;
      while ((exp_q.size() != 0 || mon_busy) && guard < 3000) begin
         @(posedge clk);
         guard++;
      end
      check("frames_drained", {31'd0, guard >= 3000}, 32'd0);
      @(negedge clk);
      check("led_peak", {25'd0, led[6:0]}, {25'd0, exp_led});
   endtask

   // Monitor: decode each frame on TX[1] and compare with the scoreboard.
   initial begin : monitor
      logic        prev_b;
      logic [39:0] bits;
      logic [31:0] got;
      logic        framing_ok;
      int          j;
      prev_b = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en && tx[2] === 1'b1 && !prev_b) begin
            mon_busy = 1'b1;
            repeat (4) @(negedge clk);
            for (int i = 0; i < 40; i++) begin
               bits[i] = tx[1];
               if (i != 39) repeat (8) @(negedge clk);
            end
            j = 316;
            while (tx[2] === 1'b1 && j < 400) begin
               @(negedge clk);
               j++;
            end
            framing_ok = 1'b1;
            got = '0;
            for (int k = 0; k < 4; k++) begin
               if (bits[10*k] !== 1'b0 || bits[10*k+9] !== 1'b1) framing_ok = 1'b0;
               for (int b = 7; b >= 0; b--) got = {got[30:0], bits[10*k+1+b]};
            end
            check("framing", {31'd0, framing_ok}, 32'd1);
            check("busy_len", j, FRAME_CYC);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_frame actual=%08h required=none", got);
            end else begin
               check("frame", got, exp_q.pop_front());
            end
            mon_busy = 1'b0;
         end
         prev_b = tx[2];
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int guard;
      // Reset state and encode clock pattern.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_tx", {30'd0, tx}, 32'd1);
      check("reset_led", {24'd0, led}, 32'd0);
      check("reset_enc", {31'd0, enc}, 32'd0);
      check("pins", {29'd0, pga, dith, rand_o}, 32'd5);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("enc_seq", {31'd0, enc}, {31'd0, (k % 4) >= 2});
      end
      // CLKOUTA activity indicator.
      clk_sel = 1'b1;
      repeat (8) @(negedge clk);
      check("alive_on", {31'd0, led[7]}, 32'd1);
      repeat (20) @(negedge clk);
      check("alive_hold", {31'd0, led[7]}, 32'd1);
      clk_sel = 1'b0;
      repeat (2) @(negedge clk);
      check("alive_decay", {31'd0, led[7]}, 32'd1);
      repeat ((1 << AL) + 8) @(negedge clk);
      check("alive_off", {31'd0, led[7]}, 32'd0);

      // Constant +100.
      samples.delete();
      for (int i = 0; i < NS; i++) samples.push_back(100);
      model_frames();
      run_samples();
      // Full-scale negative.
      samples.delete();
      for (int i = 0; i < NS; i++) samples.push_back(-32768);
      model_frames();
      run_samples();
      // Alternating +3/-4.
      samples.delete();
      for (int i = 0; i < NS; i++) samples.push_back((i % 2 == 0) ? 3 : -4);
      model_frames();
      run_samples();
      // Random, seven blocks: only blocks 0 and 6 fit around the busy UART.
      samples.delete();
      for (int i = 0; i < 7 * NS; i++) samples.push_back(int'($urandom_range(65535)) - 32768);
      model_frames();
      run_samples();
      // Random single blocks with narrower ranges.
      for (int r = 0; r < 2; r++) begin
         samples.delete();
         for (int i = 0; i < NS; i++) samples.push_back(int'($urandom_range(2047)) - 1024);
         model_frames();
         run_samples();
      end

      // Reset asserted in the middle of a frame.
      mon_en = 1'b0;
      da  = 16'($urandom_range(65535));
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      guard = 0;
      while (tx[2] !== 1'b1 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check("frame_seen", {31'd0, guard >= 200}, 32'd0);
      check("start_bit", {31'd0, tx[1]}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_mid_tx", {30'd0, tx}, 32'd1);
      check("rst_mid_led", {24'd0, led}, 32'd0);
      #1 rst = 1'b0;
      repeat (40) @(negedge clk);
      check("no_resume", {30'd0, tx}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
